// File: rtl/issue_ctrl_pkg.sv
// Shared control constants for the issue controller: decoder codes,
// FSM state encoding and the in-flight write-tracking slot layout.
package issue_ctrl_pkg;

   // Register-port usage codes from the decoder (rdN = read ports, wrN = write port).
   localparam logic [2:0] RD0WR0 = 3'd0;
   localparam logic [2:0] RD1WR1 = 3'd1;
   localparam logic [2:0] RD2WR1 = 3'd2;
   localparam logic [2:0] RD1WR0 = 3'd3;
   localparam logic [2:0] RD0WR1 = 3'd4;

   // Memory operation codes.
   localparam logic [2:0] MEMNOP = 3'd0;
   localparam logic [2:0] MEMWLD = 3'd1;
   localparam logic [2:0] MEMWST = 3'd2;

   // ALU operation codes carried by the decoder alongside regop/memop.
   localparam logic [2:0] ALUNOP = 3'd0;
   localparam logic [2:0] ALUADD = 3'd1;
   localparam logic [2:0] ALUSUB = 3'd2;
   localparam logic [2:0] ALUAND = 3'd3;
   localparam logic [2:0] ALUOR  = 3'd4;

   localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

   // Controller state: running, holding for a register hazard, or waiting on memory.
   typedef enum logic [1:0] {
      RUN  = 2'd0,
      HAZ  = 2'd1,
      MEMW = 2'd2
   } state_e;

   // One in-flight instruction as seen by the hazard logic.
   typedef struct packed {
      logic       valid;
      logic       wen;
      logic [4:0] waddr;
      logic [2:0] memop;
   } slot_t;

   localparam slot_t SLOT_EMPTY = '0;

   function automatic logic uses_a(input logic [2:0] code);
      return (code == RD1WR1) || (code == RD2WR1) || (code == RD1WR0);
   endfunction

   function automatic logic uses_b(input logic [2:0] code);
      return (code == RD2WR1);
   endfunction

   function automatic logic uses_w(input logic [2:0] code);
      return (code == RD1WR1) || (code == RD2WR1) || (code == RD0WR1);
   endfunction

endpackage

// File: rtl/issue_slot.sv
// Single write-tracking slot: holds on freeze, otherwise advances,
// optionally turning the incoming entry into a bubble.
module issue_slot
   import issue_ctrl_pkg::*;
(
   input  logic  clk,
   input  logic  reset_b,
   input  logic  hold_i,
   input  logic  bubble_i,
   input  slot_t slot_i,
   output slot_t slot_o
);

   slot_t slot_q;
   slot_t slot_d;

   // Next-state: keep the current entry on hold, else take the upstream one.
   always_comb begin
      slot_d = slot_q;
      if (!hold_i) begin
         slot_d = slot_i;
         if (bubble_i) begin
            slot_d.valid = 1'b0;
         end
      end
   end

   // Slot register, cleared by reset so nothing in flight survives it.
   always_ff @(posedge clk) begin
      if (!reset_b) begin
         slot_q <= SLOT_EMPTY;
      end else begin
         slot_q <= slot_d;
      end
   end

   assign slot_o = slot_q;

endmodule

// File: rtl/issue_ctrl.sv
// Issue controller: scoreboards writes in flight through EX/MEM/WB,
// stalls dependent instructions and freezes the pipe on memory waits.
module issue_ctrl
   import issue_ctrl_pkg::*;
#(
   parameter int PIPE_SLOTS = 3
)(
   input  logic        clk,
   input  logic        reset_b,
   input  logic        instr_vld,
   input  logic [2:0]  regop,
   input  logic [2:0]  memop,
   input  logic [4:0]  rrdaddra,
   input  logic [4:0]  rrdaddrb,
   input  logic [4:0]  rwraddrd,
   input  logic        mem_ack,
   output logic        stall,
   output logic        issue,
   output logic        freeze,
   output logic        mem_req,
   output logic        wb_wen,
   output logic [4:0]  wb_waddr,
   output logic [15:0] stall_cnt
);

   // Slot 0 is EX, slot 1 is MEM, the last slot is WB.
   localparam int MEM_IDX = 1;
   localparam int WB_IDX  = PIPE_SLOTS - 1;

   slot_t       slot_q  [PIPE_SLOTS];
   slot_t       slot_in [PIPE_SLOTS];
   slot_t       issue_pkt;
   logic        match_a;
   logic        match_b;
   logic        hazard;
   state_e      state_q;
   state_e      state_d;
   logic [15:0] stall_cnt_q;
   logic [15:0] stall_cnt_d;

   // Build the entry that enters EX when the current instruction issues.
   always_comb begin
      issue_pkt       = SLOT_EMPTY;
      issue_pkt.valid = 1'b1;
      issue_pkt.wen   = uses_w(regop);
      issue_pkt.waddr = rwraddrd;
      issue_pkt.memop = memop;
   end

   genvar gi;
   generate
      for (gi = 0; gi < PIPE_SLOTS; gi++) begin : g_slot
         if (gi == 0) begin : g_head
            assign slot_in[gi] = issue_pkt;
            issue_slot u_slot (
               .clk      (clk),
               .reset_b  (reset_b),
               .hold_i   (freeze),
               .bubble_i (~issue),
               .slot_i   (slot_in[gi]),
               .slot_o   (slot_q[gi])
            );
         end else begin : g_tail
            assign slot_in[gi] = slot_q[gi-1];
            issue_slot u_slot (
               .clk      (clk),
               .reset_b  (reset_b),
               .hold_i   (freeze),
               .bubble_i (1'b0),
               .slot_i   (slot_in[gi]),
               .slot_o   (slot_q[gi])
            );
         end
      end
   endgenerate

   // Compare both read addresses against every pending write (r0 included).
   always_comb begin
      match_a = 1'b0;
      match_b = 1'b0;
      for (int i = 0; i < PIPE_SLOTS; i++) begin
         if (slot_q[i].valid && slot_q[i].wen) begin
            if (slot_q[i].waddr == rrdaddra) match_a = 1'b1;
            if (slot_q[i].waddr == rrdaddrb) match_b = 1'b1;
         end
      end
   end

   assign hazard   = instr_vld && ((uses_a(regop) && match_a) || (uses_b(regop) && match_b));
   assign mem_req  = slot_q[MEM_IDX].valid && (slot_q[MEM_IDX].memop != MEMNOP);
   // An ack in the same cycle as the request means no wait at all.
   assign freeze   = mem_req && !mem_ack;
   assign issue    = instr_vld && !hazard && !freeze;
   assign stall    = instr_vld && !issue;
   assign wb_wen   = slot_q[WB_IDX].valid && slot_q[WB_IDX].wen && !freeze;
   assign wb_waddr = slot_q[WB_IDX].waddr;

   // Next state: memory wait dominates a register hazard.
   always_comb begin
      state_d = RUN;
      if (freeze) begin
         state_d = MEMW;
      end else if (hazard) begin
         state_d = HAZ;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!reset_b) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Saturating increment of the stall counter.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != STALL_CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   // Stall counter register.
   always_ff @(posedge clk) begin
      if (!reset_b) begin
         stall_cnt_q <= 16'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: inputs change on the falling edge,
// outputs are checked 1ns later, well away from the rising edge.
module tb_issue_ctrl;
   import issue_ctrl_pkg::*;

   logic        clk;
   logic        reset_b;
   logic        instr_vld;
   logic [2:0]  regop;
   logic [2:0]  memop;
   logic [4:0]  rrdaddra;
   logic [4:0]  rrdaddrb;
   logic [4:0]  rwraddrd;
   logic        mem_ack;
   logic        stall;
   logic        issue;
   logic        freeze;
   logic        mem_req;
   logic        wb_wen;
   logic [4:0]  wb_waddr;
   logic [15:0] stall_cnt;

   int checks = 0;
   int errors = 0;

   issue_ctrl #(.PIPE_SLOTS(3)) dut (
      .clk       (clk),
      .reset_b   (reset_b),
      .instr_vld (instr_vld),
      .regop     (regop),
      .memop     (memop),
      .rrdaddra  (rrdaddra),
      .rrdaddrb  (rrdaddrb),
      .rwraddrd  (rwraddrd),
      .mem_ack   (mem_ack),
      .stall     (stall),
      .issue     (issue),
      .freeze    (freeze),
      .mem_req   (mem_req),
      .wb_wen    (wb_wen),
      .wb_waddr  (wb_waddr),
      .stall_cnt (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic present(input logic v, input logic [2:0] rop, input logic [2:0] mop,
                          input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
      instr_vld = v;
      regop     = rop;
      memop     = mop;
      rrdaddra  = a;
      rrdaddrb  = b;
      rwraddrd  = d;
   endtask

   task automatic idle();
      present(1'b0, RD0WR0, MEMNOP, 5'd0, 5'd0, 5'd0);
   endtask

   task automatic drain(input int n);
      idle();
      mem_ack = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      reset_b = 1'b0;
      mem_ack = 1'b0;
      idle();
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      checks++; if (mem_req !== 1'b0 || freeze !== 1'b0 || wb_wen !== 1'b0) begin errors++;
         $display("FAIL reset_outs mem_req=%0b freeze=%0b wb_wen=%0b want 0 0 0", mem_req, freeze, wb_wen); end
      checks++; if (stall_cnt !== 16'd0) begin errors++;
         $display("FAIL reset_stall_cnt got %0h want 0", stall_cnt); end
      checks++; if (dut.state_q !== RUN) begin errors++;
         $display("FAIL reset_state got %0d want %0d", dut.state_q, RUN); end
      checks++; if (issue !== 1'b0 || stall !== 1'b0) begin errors++;
         $display("FAIL reset_idle issue=%0b stall=%0b want 0 0", issue, stall); end
      present(1'b1, RD1WR1, MEMNOP, 5'd1, 5'd0, 5'd2); #1;
      checks++; if (issue !== 1'b1 || stall !== 1'b0) begin errors++;
         $display("FAIL reset_follow issue=%0b stall=%0b want 1 0", issue, stall); end
      @(negedge clk);
      idle();
      reset_b = 1'b1;
      $display("test_reset done");
   endtask

   task automatic test_independent();
      @(negedge clk); present(1'b1, RD2WR1, MEMNOP, 5'd2, 5'd3, 5'd1); #1;
      checks++; if (issue !== 1'b1 || stall !== 1'b0) begin errors++;
         $display("FAIL indep_first issue=%0b stall=%0b want 1 0", issue, stall); end
      @(negedge clk); present(1'b1, RD2WR1, MEMNOP, 5'd5, 5'd6, 5'd4); #1;
      checks++; if (issue !== 1'b1 || stall !== 1'b0) begin errors++;
         $display("FAIL indep_second issue=%0b stall=%0b want 1 0", issue, stall); end
      @(negedge clk); idle(); #1;
      checks++; if (wb_wen !== 1'b0) begin errors++;
         $display("FAIL indep_wb_early got %0b want 0", wb_wen); end
      @(negedge clk); #1;
      checks++; if (wb_wen !== 1'b1 || wb_waddr !== 5'd1) begin errors++;
         $display("FAIL indep_wb_r1 wen=%0b waddr=%0d want 1 1", wb_wen, wb_waddr); end
      @(negedge clk); #1;
      checks++; if (wb_wen !== 1'b1 || wb_waddr !== 5'd4) begin errors++;
         $display("FAIL indep_wb_r4 wen=%0b waddr=%0d want 1 4", wb_wen, wb_waddr); end
      @(negedge clk); #1;
      checks++; if (wb_wen !== 1'b0) begin errors++;
         $display("FAIL indep_wb_late got %0b want 0", wb_wen); end
      $display("test_independent done");
   endtask

   task automatic test_raw();
      @(negedge clk); present(1'b1, RD2WR1, MEMNOP, 5'd1, 5'd2, 5'd7); #1;
      checks++; if (issue !== 1'b1) begin errors++;
         $display("FAIL raw_producer issue=%0b want 1", issue); end
      @(negedge clk); present(1'b1, RD2WR1, MEMNOP, 5'd7, 5'd3, 5'd8);
      for (int c = 1; c <= 3; c++) begin
         if (c > 1) @(negedge clk);
         #1;
         checks++; if (stall !== 1'b1 || issue !== 1'b0) begin errors++;
            $display("FAIL raw_stall_c%0d stall=%0b issue=%0b want 1 0", c, stall, issue); end
         if (c == 2) begin
            checks++; if (dut.state_q !== HAZ) begin errors++;
               $display("FAIL raw_state got %0d want %0d", dut.state_q, HAZ); end
         end
      end
      @(negedge clk); #1;
      checks++; if (issue !== 1'b1 || stall !== 1'b0) begin errors++;
         $display("FAIL raw_release issue=%0b stall=%0b want 1 0", issue, stall); end
      checks++; if (stall_cnt !== 16'd3) begin errors++;
         $display("FAIL raw_stall_cnt got %0d want 3", stall_cnt); end
      drain(4);
      $display("test_raw done");
   endtask

   task automatic test_memwait();
      @(negedge clk); present(1'b1, RD1WR1, MEMWLD, 5'd2, 5'd0, 5'd9); #1;
      checks++; if (issue !== 1'b1) begin errors++;
         $display("FAIL memw_ld_issue issue=%0b want 1", issue); end
      @(negedge clk); idle(); #1;
      checks++; if (mem_req !== 1'b0 || freeze !== 1'b0) begin errors++;
         $display("FAIL memw_pre mem_req=%0b freeze=%0b want 0 0", mem_req, freeze); end
      @(negedge clk); #1;
      checks++; if (mem_req !== 1'b1 || freeze !== 1'b1) begin errors++;
         $display("FAIL memw_c2 mem_req=%0b freeze=%0b want 1 1", mem_req, freeze); end
      for (int c = 3; c <= 5; c++) begin
         @(negedge clk); present(1'b1, RD2WR1, MEMNOP, 5'd11, 5'd12, 5'd10); #1;
         checks++; if (freeze !== 1'b1 || stall !== 1'b1 || issue !== 1'b0 || mem_req !== 1'b1 || wb_wen !== 1'b0) begin errors++;
            $display("FAIL memw_hold_c%0d freeze=%0b stall=%0b issue=%0b mem_req=%0b wb_wen=%0b want 1 1 0 1 0",
                     c, freeze, stall, issue, mem_req, wb_wen); end
         if (c == 3) begin
            checks++; if (dut.state_q !== MEMW) begin errors++;
               $display("FAIL memw_state got %0d want %0d", dut.state_q, MEMW); end
         end
      end
      @(negedge clk); mem_ack = 1'b1; #1;
      checks++; if (freeze !== 1'b0 || issue !== 1'b1) begin errors++;
         $display("FAIL memw_ack freeze=%0b issue=%0b want 0 1", freeze, issue); end
      @(negedge clk); mem_ack = 1'b0; idle(); #1;
      checks++; if (wb_wen !== 1'b1 || wb_waddr !== 5'd9 || mem_req !== 1'b0) begin errors++;
         $display("FAIL memw_wb wen=%0b waddr=%0d mem_req=%0b want 1 9 0", wb_wen, wb_waddr, mem_req); end
      checks++; if (stall_cnt !== 16'd6) begin errors++;
         $display("FAIL memw_stall_cnt got %0d want 6", stall_cnt); end
      drain(4);
      $display("test_memwait done");
   endtask

   task automatic test_ack_edges();
      @(negedge clk); present(1'b1, RD1WR1, MEMWLD, 5'd1, 5'd0, 5'd13); #1;
      @(negedge clk); idle(); mem_ack = 1'b1; #1;
      checks++; if (freeze !== 1'b0 || mem_req !== 1'b0) begin errors++;
         $display("FAIL ack_stray freeze=%0b mem_req=%0b want 0 0", freeze, mem_req); end
      @(negedge clk); #1;
      checks++; if (mem_req !== 1'b1 || freeze !== 1'b0) begin errors++;
         $display("FAIL ack_same_cycle mem_req=%0b freeze=%0b want 1 0", mem_req, freeze); end
      @(negedge clk); mem_ack = 1'b0; #1;
      checks++; if (wb_wen !== 1'b1 || wb_waddr !== 5'd13 || mem_req !== 1'b0) begin errors++;
         $display("FAIL ack_wb wen=%0b waddr=%0d mem_req=%0b want 1 13 0", wb_wen, wb_waddr, mem_req); end
      drain(4);
      $display("test_ack_edges done");
   endtask

   task automatic test_haz_freeze();
      @(negedge clk); present(1'b1, RD1WR1, MEMWLD, 5'd2, 5'd0, 5'd9); #1;
      @(negedge clk); present(1'b1, RD2WR1, MEMNOP, 5'd9, 5'd3, 5'd14); #1;
      checks++; if (stall !== 1'b1) begin errors++;
         $display("FAIL hf_c1_stall got %0b want 1", stall); end
      @(negedge clk); #1;
      checks++; if (freeze !== 1'b1 || dut.state_q !== HAZ) begin errors++;
         $display("FAIL hf_c2 freeze=%0b state=%0d want 1 %0d", freeze, dut.state_q, HAZ); end
      @(negedge clk); #1;
      checks++; if (dut.state_q !== MEMW) begin errors++;
         $display("FAIL hf_c3_state got %0d want %0d", dut.state_q, MEMW); end
      @(negedge clk); mem_ack = 1'b1; #1;
      checks++; if (dut.state_q !== MEMW || freeze !== 1'b0 || stall !== 1'b1) begin errors++;
         $display("FAIL hf_c4 state=%0d freeze=%0b stall=%0b want %0d 0 1", dut.state_q, freeze, stall, MEMW); end
      @(negedge clk); mem_ack = 1'b0; #1;
      checks++; if (dut.state_q !== HAZ || stall !== 1'b1 || wb_wen !== 1'b1 || wb_waddr !== 5'd9) begin errors++;
         $display("FAIL hf_c5 state=%0d stall=%0b wb_wen=%0b waddr=%0d want %0d 1 1 9",
                  dut.state_q, stall, wb_wen, wb_waddr, HAZ); end
      @(negedge clk); #1;
      checks++; if (issue !== 1'b1 || stall_cnt !== 16'd11) begin errors++;
         $display("FAIL hf_c6 issue=%0b stall_cnt=%0d want 1 11", issue, stall_cnt); end
      @(negedge clk); idle(); #1;
      checks++; if (dut.state_q !== RUN) begin errors++;
         $display("FAIL hf_c7_state got %0d want %0d", dut.state_q, RUN); end
      drain(4);
      $display("test_haz_freeze done");
   endtask

   task automatic test_store();
      @(negedge clk); present(1'b1, RD2WR1, MEMNOP, 5'd1, 5'd2, 5'd5); #1;
      @(negedge clk); present(1'b1, RD1WR0, MEMWST, 5'd5, 5'd0, 5'd20);
      for (int c = 1; c <= 3; c++) begin
         if (c > 1) @(negedge clk);
         #1;
         checks++; if (stall !== 1'b1) begin errors++;
            $display("FAIL st_stall_c%0d got %0b want 1", c, stall); end
      end
      @(negedge clk); #1;
      checks++; if (issue !== 1'b1 || stall_cnt !== 16'd14) begin errors++;
         $display("FAIL st_issue issue=%0b stall_cnt=%0d want 1 14", issue, stall_cnt); end
      @(negedge clk); present(1'b1, RD2WR1, MEMNOP, 5'd20, 5'd20, 5'd21); #1;
      checks++; if (issue !== 1'b1 || stall !== 1'b0) begin errors++;
         $display("FAIL st_no_match issue=%0b stall=%0b want 1 0", issue, stall); end
      @(negedge clk); idle(); mem_ack = 1'b1; #1;
      checks++; if (mem_req !== 1'b1 || freeze !== 1'b0) begin errors++;
         $display("FAIL st_mem mem_req=%0b freeze=%0b want 1 0", mem_req, freeze); end
      @(negedge clk); mem_ack = 1'b0; #1;
      checks++; if (wb_wen !== 1'b0 || mem_req !== 1'b0) begin errors++;
         $display("FAIL st_wb_store wb_wen=%0b mem_req=%0b want 0 0", wb_wen, mem_req); end
      @(negedge clk); #1;
      checks++; if (wb_wen !== 1'b1 || wb_waddr !== 5'd21) begin errors++;
         $display("FAIL st_wb_r21 wen=%0b waddr=%0d want 1 21", wb_wen, wb_waddr); end
      drain(4);
      $display("test_store done");
   endtask

   task automatic test_reset_memw();
      @(negedge clk); present(1'b1, RD1WR1, MEMWLD, 5'd2, 5'd0, 5'd9); #1;
      @(negedge clk); idle(); #1;
      @(negedge clk); #1;
      checks++; if (freeze !== 1'b1) begin errors++;
         $display("FAIL rm_wait freeze=%0b want 1", freeze); end
      @(negedge clk); reset_b = 1'b0; #1;
      @(negedge clk); reset_b = 1'b1; #1;
      checks++; if (mem_req !== 1'b0 || freeze !== 1'b0 || wb_wen !== 1'b0 || stall_cnt !== 16'd0) begin errors++;
         $display("FAIL rm_after mem_req=%0b freeze=%0b wb_wen=%0b stall_cnt=%0d want 0 0 0 0",
                  mem_req, freeze, wb_wen, stall_cnt); end
      checks++; if (dut.state_q !== RUN) begin errors++;
         $display("FAIL rm_state got %0d want %0d", dut.state_q, RUN); end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #1;
         checks++; if (wb_wen !== 1'b0) begin errors++;
            $display("FAIL rm_no_wb_c%0d got %0b want 0", c, wb_wen); end
      end
      $display("test_reset_memw done");
   endtask

   task automatic test_saturate();
      @(negedge clk); present(1'b1, RD2WR1, MEMNOP, 5'd1, 5'd1, 5'd3); #1;
      @(negedge clk);
      force dut.stall_cnt_q = 16'hFFFE;
      present(1'b1, RD1WR1, MEMNOP, 5'd3, 5'd0, 5'd4);
      #1;
      release dut.stall_cnt_q;
      #1;
      checks++; if (stall !== 1'b1 || stall_cnt !== 16'hFFFE) begin errors++;
         $display("FAIL sat_preload stall=%0b stall_cnt=%0h want 1 fffe", stall, stall_cnt); end
      for (int c = 2; c <= 3; c++) begin
         @(negedge clk); #1;
         checks++; if (stall_cnt !== 16'hFFFF) begin errors++;
            $display("FAIL sat_c%0d stall_cnt=%0h want ffff", c, stall_cnt); end
      end
      @(negedge clk); #1;
      checks++; if (issue !== 1'b1 || stall_cnt !== 16'hFFFF) begin errors++;
         $display("FAIL sat_final issue=%0b stall_cnt=%0h want 1 ffff", issue, stall_cnt); end
      drain(4);
      $display("test_saturate done");
   endtask

   initial begin
      test_reset();
      test_independent();
      test_raw();
      test_memwait();
      test_ack_edges();
      test_haz_freeze();
      test_store();
      test_reset_memw();
      test_saturate();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/issue_ctrl.md
ISSUE_CTRL -- requirements
Module: issue_ctrl

Interface
REQ-001 The module SHALL have a single clock and a synchronous, active-low reset: clk is the one clock and reset_b is the synchronous, active-low reset.
REQ-002 Parameter: PIPE_SLOTS, default 3, number of in-flight write-tracking slots (EX, MEM, WB).
REQ-003 Ports:
- clk  in  1  rising-edge clock
- reset_b  in  1  synchronous active-low reset
- instr_vld  in  1  decoded instruction present at issue
- regop  in  3  decoder register-port code
- memop  in  3  decoder memory code
- rrdaddra  in  5  read address A
- rrdaddrb  in  5  read address B
- rwraddrd  in  5  write address D
- mem_ack  in  1  data memory completed current request
- stall  out  1  fetch/decode hold current instruction
- issue  out  1  instruction enters EX this cycle
- freeze  out  1  hold EX/MEM/WB pipeline registers
- mem_req  out  1  memory operation pending in MEM slot
- wb_wen  out  1  register-file write enable
- wb_waddr  out  5  register-file write address
- stall_cnt  out  16  saturating stall-cycle count

Function
REQ-004 Read-use SHALL be decoded from regop: port A used for rd1wr1, rd2wr1 and rd1wr0; port B used only for rd2wr1; write used for rd1wr1, rd2wr1 and rd0wr1.
REQ-005 Each slot SHALL hold {valid, wen, waddr[0:4], memop[0:2]}.
REQ-006 match(x) SHALL be true when any slot has valid=1, wen=1 and waddr==x; register 0 gets no special treatment.
REQ-007 hazard SHALL equal instr_vld AND ((A used AND match(rrdaddra)) OR (B used AND match(rrdaddrb))), combinationally.
REQ-008 freeze SHALL equal mem_req AND NOT mem_ack, combinationally.
REQ-009 mem_req SHALL be 1 whenever the MEM slot is valid with memop != memnop.
REQ-010 issue SHALL equal instr_vld AND NOT hazard AND NOT freeze.
REQ-011 stall SHALL equal instr_vld AND NOT issue.
REQ-012 On each clock edge with freeze=0, WB<=MEM, MEM<=EX, and EX<=issued instruction; EX<=bubble (valid=0) when issue=0.
REQ-013 On each clock edge with freeze=1, all slots SHALL hold their values.
REQ-014 wb_wen SHALL equal WB.valid AND WB.wen AND NOT freeze; wb_waddr SHALL equal WB.waddr.
REQ-015 An instruction without a hazard SHALL issue in the same cycle it is presented (zero-cycle issue latency).
REQ-016 A dependent instruction following its producer back-to-back SHALL stall exactly 3 cycles when there is no memory wait.
REQ-017 FSM states SHALL be RUN, HAZ and MEMW, with registered next state:
- next state is MEMW when freeze=1;
- else HAZ when hazard=1;
- else RUN.
- MEMW has priority over HAZ when both conditions hold in the same cycle.
REQ-018 The state SHALL be observable in the bench via hierarchy only; it is not a port.
REQ-019 stall_cnt SHALL increment by 1 on each edge with stall=1, saturate at 16'hFFFF and never wrap.
REQ-020 When mem_ack is asserted without mem_req, it SHALL be ignored.
REQ-021 When mem_ack arrives in the same cycle that mem_req first rises, no freeze cycle SHALL occur.

Reset
REQ-022 When reset_b=0 at an edge, all slots SHALL go to valid=0, the state to RUN and stall_cnt to 0.
REQ-023 After that edge, mem_req, wb_wen and freeze SHALL be 0; stall and issue then follow instr_vld.
REQ-024 A reset asserted mid-memory-wait or mid-hazard SHALL abandon the in-flight operation with no register-file write.

Structure
REQ-025 The regop, memop and alunop codes (memnop, memwld, memwst, rd*wr* codes) SHALL be in the shared control constants header together with the FSM state encodings.
REQ-026 One sub-module, issue_slot (a single tracking-slot register with hold/advance/bubble), SHALL be instantiated PIPE_SLOTS times.

Verification
REQ-027 Independent stream: wadd r1<-r2,r3 then wadd r4<-r5,r6 -> both issue back-to-back, stall=0, and wb_wen with waddr 1 then 4 appears 3 cycles after each issue.
REQ-028 RAW hazard: wadd r7<-r1,r2 followed by wadd r8<-r7,r3 -> stall=1 for 3 cycles, then issue; stall_cnt=3.
REQ-029 Memory wait: wld r9 with mem_ack held low for 4 cycles after mem_req -> freeze=1 for 4 cycles, slots hold, wb_wen for r9 follows after ack, and a following independent instruction is stalled during the wait.
REQ-030 Simultaneous hazard and freeze: wld r9 waiting while the next instruction reads r9 -> state is MEMW (not HAZ) until ack, then HAZ until r9 clears WB.
REQ-031 wst reading r5 (rd1wr0) behind wadd r5 -> stalls; a wst with no write-use creates no match for later readers.
REQ-032 Reset during MEMW: reset_b=0 for 1 cycle -> mem_req=0, no wb_wen, stall_cnt=0, state=RUN next cycle; saturation test with forced stall_cnt=16'hFFFE and 3 stall cycles -> stall_cnt=16'hFFFF.
